// File: rtl/egg_timer_pkg.sv
// Shared types and helpers for the egg-timer controller slice.
package egg_timer_pkg;

    // Width of a two-digit BCD time value (tens nibble, ones nibble).
    localparam int BCD_W = 8;

    // Controller states; encodings are visible on the state output.
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_RUN   = 3'd2,
        ST_PAUSE = 3'd3,
        ST_ALARM = 3'd4
    } state_e;

    // True when both nibbles hold a decimal digit 0..9.
    function automatic logic isBcdValid(input logic [BCD_W-1:0] value);
        return (value[7:4] <= 4'd9) && (value[3:0] <= 4'd9);
    endfunction

endpackage

// File: rtl/egg_timer_tick_prescaler.sv
// Free-running divider producing a one-cycle tick every TICK_DIV enabled cycles.
// The count holds while disabled so a paused countdown resumes mid-second.
module tick_prescaler #(
    parameter int TICK_DIV = 50000000
) (
    input  logic clk,
    input  logic reset,
    input  logic enable_i,
    input  logic clear_i,
    output logic tick_o
);

    localparam int CNT_W = $clog2(TICK_DIV);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;
    logic             tick;

    // Next count: clear wins, otherwise advance and wrap when enabled.
    always_comb begin
        count_d = count_q;
        tick    = 1'b0;
        if (clear_i) begin
            count_d = '0;
        end else if (enable_i) begin
            if (count_q == LAST) begin
                count_d = '0;
                tick    = 1'b1;
            end else begin
                count_d = count_q + 1'b1;
            end
        end
    end

    // Count register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign tick_o = tick;

endmodule

// File: rtl/egg_timer_ctrl.sv
// Sequencing controller for the egg-timer countdown datapath: turns user
// pulses into load/decrement strobes, raises and times out the alarm.
module egg_timer_ctrl
    import egg_timer_pkg::*;
#(
    parameter int TICK_DIV    = 50000000,
    parameter int ALARM_TICKS = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start_stop,
    input  logic             clear,
    input  logic [BCD_W-1:0] set_time,
    input  logic [BCD_W-1:0] cur_time,
    output logic             write_en,
    output logic             decrement_en,
    output logic [BCD_W-1:0] load_value,
    output logic             alarm,
    output logic             running,
    output logic             set_error,
    output logic [2:0]       state
);

    localparam int ACNT_W = $clog2(ALARM_TICKS + 1);

    state_e             state_q,     state_d;
    logic               writeEn_q,   writeEn_d;
    logic               decEn_q,     decEn_d;
    logic [BCD_W-1:0]   loadValue_q, loadValue_d;
    logic               setError_q,  setError_d;
    logic               alarm_q,     alarm_d;
    logic               running_q,   running_d;
    logic [ACNT_W-1:0]  alarmCnt_q,  alarmCnt_d;

    logic tick;
    logic presEnable;
    logic presClear;

    // The second counter runs during RUN and ALARM, restarts on LOAD and clear.
    assign presEnable = (state_q == ST_RUN) || (state_q == ST_ALARM);
    assign presClear  = clear || (state_q == ST_LOAD);

    tick_prescaler #(
        .TICK_DIV(TICK_DIV)
    ) u_prescaler (
        .clk     (clk),
        .reset   (reset),
        .enable_i(presEnable),
        .clear_i (presClear),
        .tick_o  (tick)
    );

    // Next state and next registered outputs; clear beats start_stop beats tick.
    always_comb begin
        state_d     = state_q;
        writeEn_d   = 1'b0;
        decEn_d     = 1'b0;
        loadValue_d = '0;
        setError_d  = 1'b0;
        alarmCnt_d  = alarmCnt_q;

        if (clear) begin
            state_d     = ST_IDLE;
            writeEn_d   = 1'b1;
            loadValue_d = '0;
            alarmCnt_d  = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start_stop) begin
                        if (isBcdValid(set_time) && (set_time != '0)) begin
                            state_d     = ST_LOAD;
                            writeEn_d   = 1'b1;
                            loadValue_d = set_time;
                        end else begin
                            setError_d = 1'b1;
                        end
                    end
                end
                ST_LOAD: begin
                    state_d = ST_RUN;
                end
                ST_RUN: begin
                    if (start_stop) begin
                        state_d = ST_PAUSE;
                    end else if (cur_time == '0) begin
                        state_d    = ST_ALARM;
                        alarmCnt_d = '0;
                    end else if (tick) begin
                        decEn_d = 1'b1;
                    end
                end
                ST_PAUSE: begin
                    if (start_stop) begin
                        state_d = ST_RUN;
                    end
                end
                ST_ALARM: begin
                    if (start_stop) begin
                        state_d    = ST_IDLE;
                        alarmCnt_d = '0;
                    end else if (tick) begin
                        if (alarmCnt_q == ACNT_W'(ALARM_TICKS - 1)) begin
                            state_d    = ST_IDLE;
                            alarmCnt_d = '0;
                        end else begin
                            alarmCnt_d = alarmCnt_q + 1'b1;
                        end
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end

        alarm_d   = (state_d == ST_ALARM);
        running_d = (state_d == ST_RUN);
    end

    // State, strobe and status registers; every output comes straight from here.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            writeEn_q   <= 1'b0;
            decEn_q     <= 1'b0;
            loadValue_q <= '0;
            setError_q  <= 1'b0;
            alarm_q     <= 1'b0;
            running_q   <= 1'b0;
            alarmCnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            writeEn_q   <= writeEn_d;
            decEn_q     <= decEn_d;
            loadValue_q <= loadValue_d;
            setError_q  <= setError_d;
            alarm_q     <= alarm_d;
            running_q   <= running_d;
            alarmCnt_q  <= alarmCnt_d;
        end
    end

    assign write_en     = writeEn_q;
    assign decrement_en = decEn_q;
    assign load_value   = loadValue_q;
    assign set_error    = setError_q;
    assign alarm        = alarm_q;
    assign running      = running_q;
    assign state        = state_q;

endmodule
